// File: rtl/sisc_pkg.sv
// Shared encodings for the multi-cycle SISC controller: opcodes, ALU ops, FSM states
// and the branch-condition rule.
package sisc_pkg;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_REG_OP = 4'h1;
   localparam logic [3:0] OP_BRA    = 4'h2;
   localparam logic [3:0] OP_BRR    = 4'h3;
   localparam logic [3:0] OP_BNE    = 4'h4;
   localparam logic [3:0] OP_REG_IM = 4'h5;
   localparam logic [3:0] OP_LOD    = 4'h8;
   localparam logic [3:0] OP_STR    = 4'hC;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam logic [3:0] ALU_NONE  = 4'd0;
   localparam logic [3:0] ALU_REG   = 4'd1;
   localparam logic [3:0] ALU_ADDR  = 4'd2;
   localparam logic [3:0] ALU_IMM   = 4'd3;

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_t;

   // cc_hit is the OR-reduction of (mm & stat)
   function automatic logic br_taken(input logic [3:0] op, input logic cc_hit);
      logic taken;
      taken = 1'b0;
      case (op)
         OP_BRA, OP_BRR: taken = cc_hit;
         OP_BNE:         taken = !cc_hit;
         default:        taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/mem_timer.sv
// Data-memory wait timer: cleared before a MEM phase, counts stalled MEM cycles.
// expired flags the stalled cycle in which the count reaches 2^TO_W-1.
module mem_timer #(
   parameter int TO_W = 4
) (
   input  logic clk,
   input  logic rst_f,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   import sisc_pkg::*;

   localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);
   localparam logic [TO_W-1:0] CNT_LAST = TO_W'((2 ** TO_W) - 2);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // The increment happening this cycle is the one that reaches the limit
   assign expired = inc && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ctrl_mc.sv
// Multi-cycle controller: RST/FETCH/DECODE/EXEC/MEM/WB/HALT with Moore outputs,
// memory handshake with timeout, sticky halted/mem_err.
module ctrl_mc #(
   parameter int STAT_W = 4,
   parameter int ALU_W  = 4,
   parameter int TO_W   = 4
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic [3:0]        opcode,
   input  logic [STAT_W-1:0] mm,
   input  logic [STAT_W-1:0] stat,
   input  logic              dm_ready,
   output logic              rf_we,
   output logic              wb_sel,
   output logic [ALU_W-1:0]  alu_op,
   output logic              br_sel,
   output logic              pc_rst,
   output logic              pc_write,
   output logic              pc_sel,
   output logic              ir_load,
   output logic              dm_req,
   output logic              dm_we,
   output logic              halted,
   output logic              mem_err
);
   import sisc_pkg::*;

   state_t r_state;
   state_t w_next;
   logic   r_armed;
   logic   r_mem_err;
   logic   w_cc_hit;
   logic   w_mem_op;
   logic   w_clr;
   logic   w_inc;
   logic   w_expired;

   assign w_cc_hit = |(mm & stat);
   assign w_mem_op = (opcode == OP_LOD) || (opcode == OP_STR);
   assign w_clr    = (r_state == ST_EXEC);
   assign w_inc    = (r_state == ST_MEM) && w_mem_op && !dm_ready;
   assign mem_err  = r_mem_err;

   mem_timer #(.TO_W(TO_W)) u_mem_timer (
      .clk     (clk),
      .rst_f   (rst_f),
      .clr     (w_clr),
      .inc     (w_inc),
      .expired (w_expired)
   );

   // r_armed holds RST for one extra cycle so the first FETCH lands on the 2nd edge
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_state   <= ST_RST;
         r_armed   <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         r_state <= w_next;
         r_armed <= 1'b1;
         if ((r_state == ST_MEM) && w_expired) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next   = r_state;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      alu_op   = '0;
      br_sel   = 1'b0;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      ir_load  = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      halted   = 1'b0;
      case (r_state)
         ST_RST: begin
            pc_rst = 1'b1;
            if (r_armed) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            w_next   = ST_DECODE;
         end
         ST_DECODE: begin
            if (br_taken(opcode, w_cc_hit)) begin
               pc_write = 1'b1;
               pc_sel   = 1'b1;
               br_sel   = (opcode == OP_BRA);
            end
            w_next = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            case (opcode)
               OP_REG_OP:      alu_op = ALU_W'(ALU_REG);
               OP_REG_IM:      alu_op = ALU_W'(ALU_IMM);
               OP_LOD, OP_STR: alu_op = ALU_W'(ALU_ADDR);
               default:        alu_op = ALU_W'(ALU_NONE);
            endcase
            w_next = ST_MEM;
         end
         ST_MEM: begin
            if (w_mem_op) begin
               dm_req = 1'b1;
               alu_op = ALU_W'(ALU_ADDR);
               dm_we  = (opcode == OP_STR);
               // a completing access beats a timeout in the same cycle
               if (dm_ready)       w_next = ST_WB;
               else if (w_expired) w_next = ST_HALT;
            end else begin
               w_next = ST_WB;
            end
         end
         ST_WB: begin
            rf_we  = (opcode == OP_REG_OP) || (opcode == OP_REG_IM) || (opcode == OP_LOD);
            wb_sel = (opcode == OP_LOD);
            w_next = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            w_next = ST_RST;
         end
      endcase
   end

endmodule

// File: tb/tb_ctrl_mc.sv
// Bench for ctrl_mc: per-instruction expected cycle traces are built from the
// instruction-level behaviour and compared cycle by cycle.
module tb_ctrl_mc;

   localparam int TO_W   = 2;
   localparam int TO_LIM = (2 ** TO_W) - 1;

   localparam logic [3:0] NOP = 4'h0, REGOP = 4'h1, BRA = 4'h2, BRR = 4'h3, BNE = 4'h4;
   localparam logic [3:0] REGIM = 4'h5, LOD = 4'h8, STR = 4'hC, HLT = 4'hF;

   // observed-vector bit positions
   localparam int B_RF = 14, B_WB = 13, B_ALU = 9, B_BR = 8, B_PCR = 7, B_PCW = 6;
   localparam int B_PCS = 5, B_IRL = 4, B_REQ = 3, B_WE = 2, B_HLT = 1, B_ME = 0;

   logic       clk = 1'b0;
   logic       rst_f;
   logic [3:0] opcode, mm, stat;
   logic       dm_ready;
   logic       rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
   logic       dm_req, dm_we, halted, mem_err;
   logic [3:0] alu_op;
   logic [14:0] w_obs;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ctrl_mc #(.STAT_W(4), .ALU_W(4), .TO_W(TO_W)) dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .dm_ready(dm_ready), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
      .br_sel(br_sel), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
      .ir_load(ir_load), .dm_req(dm_req), .dm_we(dm_we), .halted(halted),
      .mem_err(mem_err)
   );

   assign w_obs = {rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
                   ir_load, dm_req, dm_we, halted, mem_err};

   task automatic chk(input string tag, input logic [14:0] exp);
      n_chk++;
      assert (w_obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
      end
   endtask

   function automatic logic [14:0] rst_vec();
      logic [14:0] e;
      e = '0;
      e[B_PCR] = 1'b1;
      return e;
   endfunction

   function automatic logic [3:0] alu_of(input logic [3:0] op);
      if (op == REGOP) return 4'd1;
      if (op == REGIM) return 4'd3;
      if (op == LOD || op == STR) return 4'd2;
      return 4'd0;
   endfunction

   function automatic logic taken_of(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
      if (op == BRA || op == BRR) return (m & s) != 4'd0;
      if (op == BNE) return (m & s) == 4'd0;
      return 1'b0;
   endfunction

   // pulse reset at a negedge, release it, and sit through the extra RST cycle
   task automatic do_reset(input string tag);
      @(negedge clk);
      dm_ready = 1'b0;
      rst_f = 1'b0;
      #1 chk({tag, "/rst_low"}, rst_vec());
      @(negedge clk);
      #1 chk({tag, "/rst_held"}, rst_vec());
      rst_f = 1'b1;
      @(negedge clk);
      #1 chk({tag, "/rst_arm"}, rst_vec());
   endtask

   // rdy_at: MEM cycle (1-based) in which dm_ready is driven high; 0 = never
   task automatic run_inst(input string name, input logic [3:0] op, input logic [3:0] m,
                           input logic [3:0] s, input int rdy_at);
      logic [14:0] q_e[$];
      logic        q_r[$];
      string       q_t[$];
      logic [14:0] e;
      logic        halt_seen, err_seen, mem_op;
      halt_seen = 1'b0;
      err_seen  = 1'b0;
      mem_op    = (op == LOD) || (op == STR);

      e = '0; e[B_IRL] = 1'b1; e[B_PCW] = 1'b1;
      q_e.push_back(e); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("fetch");
      e = '0;
      if (taken_of(op, m, s)) begin
         e[B_PCW] = 1'b1; e[B_PCS] = 1'b1; e[B_BR] = (op == BRA);
      end
      q_e.push_back(e); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("decode");
      if (op == HLT) begin
         halt_seen = 1'b1;
      end else begin
         e = '0; e[B_ALU +: 4] = alu_of(op);
         q_e.push_back(e); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("exec");
         if (mem_op) begin
            for (int k = 1; k <= TO_LIM; k++) begin
               e = '0; e[B_REQ] = 1'b1; e[B_ALU +: 4] = 4'd2; e[B_WE] = (op == STR);
               q_e.push_back(e); q_r.push_back(k == rdy_at); q_t.push_back($sformatf("mem%0d", k));
               if (k == rdy_at) break;
               if (k == TO_LIM) begin
                  halt_seen = 1'b1;
                  err_seen  = 1'b1;
               end
            end
         end else begin
            q_e.push_back('0); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("mem");
         end
         if (!halt_seen) begin
            e = '0;
            e[B_RF] = (op == REGOP) || (op == REGIM) || (op == LOD);
            e[B_WB] = (op == LOD);
            q_e.push_back(e); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("wb");
         end
      end
      if (halt_seen) begin
         for (int k = 0; k < 20; k++) begin
            e = '0; e[B_HLT] = 1'b1; e[B_ME] = err_seen;
            q_e.push_back(e); q_r.push_back(1'($urandom_range(0, 1))); q_t.push_back("halt");
         end
      end

      for (int i = 0; i < q_e.size(); i++) begin
         @(negedge clk);
         if (i == 0) begin
            opcode = op; mm = m; stat = s;
         end
         dm_ready = q_r[i];
         #1 chk($sformatf("%s/%s", name, q_t[i]), q_e[i]);
      end
      if (halt_seen) do_reset({name, "/exit"});
   endtask

   initial begin
      logic [14:0] e;
      logic [3:0]  op_pool[9];
      rst_f = 1'b0; opcode = NOP; mm = '0; stat = '0; dm_ready = 1'b0;
      #1 chk("por", rst_vec());
      @(negedge clk);
      #1 chk("por_held", rst_vec());
      rst_f = 1'b1;
      @(negedge clk);
      #1 chk("first_arm", rst_vec());

      run_inst("regop",     REGOP, 4'b0000, 4'b0000, 0);
      run_inst("bne_take",  BNE,   4'b0010, 4'b0000, 0);
      run_inst("bne_skip",  BNE,   4'b0010, 4'b0010, 0);
      run_inst("bra_take",  BRA,   4'b0100, 4'b0110, 0);
      run_inst("bra_skip",  BRA,   4'b0100, 4'b1011, 0);
      run_inst("brr_take",  BRR,   4'b1001, 4'b0001, 0);
      run_inst("brr_skip",  BRR,   4'b1001, 4'b0110, 0);
      run_inst("regim",     REGIM, 4'b1111, 4'b1111, 0);
      run_inst("lod_wait3", LOD,   4'b0000, 4'b0000, 3);
      run_inst("str_wait3", STR,   4'b0000, 4'b0000, 3);
      run_inst("lod_fast",  LOD,   4'b0000, 4'b0000, 1);
      run_inst("undef_op",  4'h7,  4'b1111, 4'b1111, 0);
      run_inst("lod_tmo",   LOD,   4'b0000, 4'b0000, 0);
      run_inst("str_tmo",   STR,   4'b0000, 4'b0000, 0);
      run_inst("hlt",       HLT,   4'b1111, 4'b1111, 0);

      // reset pulse while an access is outstanding
      @(negedge clk);
      opcode = LOD; mm = '0; stat = '0; dm_ready = 1'b0;
      e = '0; e[B_IRL] = 1'b1; e[B_PCW] = 1'b1;
      #1 chk("midmem/fetch", e);
      @(negedge clk);
      #1 chk("midmem/decode", '0);
      @(negedge clk);
      e = '0; e[B_ALU +: 4] = 4'd2;
      #1 chk("midmem/exec", e);
      @(negedge clk);
      e = '0; e[B_REQ] = 1'b1; e[B_ALU +: 4] = 4'd2;
      #1 chk("midmem/mem1", e);
      #2 rst_f = 1'b0;
      #1 chk("midmem/async_rst", rst_vec());
      @(negedge clk);
      rst_f = 1'b1;
      @(negedge clk);
      #1 chk("midmem/arm", rst_vec());
      run_inst("after_rst", REGOP, 4'b0000, 4'b0000, 0);

      op_pool = '{NOP, REGOP, BRA, BRR, BNE, REGIM, LOD, STR, HLT};
      for (int n = 0; n < 60; n++) begin
         logic [3:0] op;
         if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
         else op = op_pool[$urandom_range(0, 8)];
         run_inst($sformatf("rnd%0d", n), op, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(0, TO_LIM + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
